// File: rtl/multi_zone_climate_ctrl.sv
// Multi-zone cold-storage climate controller: round-robin sensor scan, hysteretic fan/humidifier
// control, per-zone alarms, ASCII command interface and a two-row LCD status render.
module multi_zone_climate_ctrl #(
  parameter int unsigned NUM_ZONES     = 2,
  parameter int unsigned REFRESH_TICKS = 500_000,
  parameter int unsigned TIMEOUT_TICKS = 100_000,
  parameter int unsigned HYST          = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_ZONES-1:0] temperature,
  input  logic [8*NUM_ZONES-1:0] humidity,
  output logic [NUM_ZONES-1:0]   dht_en,
  input  logic                   dht_data_ready,
  input  logic [7:0]             chr_zone,
  input  logic [7:0]             chr_cmd,
  input  logic [7:0]             chr_val0,
  input  logic [7:0]             chr_val1,
  input  logic                   rx_msg_done,
  output logic                   cmd_err,
  output logic                   tx_req,
  input  logic                   tx_ack,
  output logic                   lcd_en,
  output logic [127:0]           lcd_row1,
  output logic [127:0]           lcd_row2,
  output logic [NUM_ZONES-1:0]   led_fan,
  output logic [NUM_ZONES-1:0]   led_hum,
  output logic [NUM_ZONES-1:0]   alarm,
  output logic [NUM_ZONES-1:0]   sensor_fault
);

  localparam int unsigned ZW          = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam logic [ZW-1:0] ZoneLast  = ZW'(NUM_ZONES - 1);
  localparam logic [31:0] RefreshLast = REFRESH_TICKS - 1;
  localparam logic [31:0] TimeoutLast = TIMEOUT_TICKS - 1;
  localparam logic [7:0]  Hyst8       = 8'(HYST);
  localparam logic [127:0] Row1Reset  = "  Cold Storage  ";
  localparam logic [127:0] Row2Reset  = "     Welcome    ";
  localparam logic [23:0] StrOn       = "ON ";
  localparam logic [23:0] StrOff      = "OFF";
  localparam logic [23:0] StrAlm      = "ALM";
  localparam logic [23:0] StrOk       = "OK ";

  typedef enum logic [2:0] {StIdle, StReq, StWait, StEval, StDisp} state_e;

  state_e               state_q, state_d;
  logic [ZW-1:0]        zone_q, zone_d;
  logic [31:0]          refresh_cnt_q, refresh_cnt_d;
  logic [31:0]          wait_cnt_q, wait_cnt_d;
  logic [7:0]           t_smp_q, t_smp_d, h_smp_q, h_smp_d;
  logic [6:0]           max_temp_q [NUM_ZONES];
  logic [6:0]           max_temp_d [NUM_ZONES];
  logic [6:0]           min_temp_q [NUM_ZONES];
  logic [6:0]           min_temp_d [NUM_ZONES];
  logic [6:0]           max_hum_q  [NUM_ZONES];
  logic [6:0]           max_hum_d  [NUM_ZONES];
  logic [6:0]           min_hum_q  [NUM_ZONES];
  logic [6:0]           min_hum_d  [NUM_ZONES];
  logic [NUM_ZONES-1:0] manual_q, manual_d;
  logic [NUM_ZONES-1:0] fan_q, fan_d, hum_q, hum_d, alarm_q, alarm_d, fault_q, fault_d;
  logic                 tx_req_q, tx_req_d, lcd_en_q, lcd_en_d, cmd_err_q, cmd_err_d;
  logic [127:0]         row1_q, row1_d, row2_q, row2_d;

  // Sensor values and thresholds of the zone being scanned
  logic [7:0] cur_t, cur_h, max_t8, fan_clr_thr;
  logic [8:0] hum_clr_thr;

  // Command decode
  logic          cmd_zone_ok, cmd_digits, cmd_ok;
  logic [ZW-1:0] cmd_zone;
  logic [7:0]    d0, d1;
  logic [6:0]    cmd_val;
  logic [15:0]   t_dd, h_dd;

  function automatic logic [15:0] two_digits(input logic [7:0] v);
    logic [7:0] c, tens, ones;
    c    = (v > 8'd99) ? 8'd99 : v;
    tens = c / 8'd10;
    ones = c % 8'd10;
    return {8'd48 + tens, 8'd48 + ones};
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'd48) && (c <= 8'd57);
  endfunction

  always_comb begin
    dht_en = '0;
    cur_t  = '0;
    cur_h  = '0;
    for (int z = 0; z < NUM_ZONES; z++) begin
      if (zone_q == ZW'(z)) begin
        dht_en[z] = (state_q == StReq) || (state_q == StWait);
        cur_t     = temperature[8*z +: 8];
        cur_h     = humidity[8*z +: 8];
      end
    end
  end

  always_comb begin
    max_t8      = {1'b0, max_temp_q[zone_q]};
    fan_clr_thr = (max_t8 >= Hyst8) ? max_t8 - Hyst8 : 8'd0;
    hum_clr_thr = {2'b00, min_hum_q[zone_q]} + {1'b0, Hyst8};
    t_dd        = fault_q[zone_q] ? "--" : two_digits(t_smp_q);
    h_dd        = fault_q[zone_q] ? "--" : two_digits(h_smp_q);
  end

  always_comb begin
    cmd_zone_ok = 1'b0;
    cmd_zone    = '0;
    for (int z = 0; z < NUM_ZONES; z++) begin
      if (chr_zone == 8'(48 + z)) begin
        cmd_zone_ok = 1'b1;
        cmd_zone    = ZW'(z);
      end
    end
    d0         = chr_val0 - 8'd48;
    d1         = chr_val1 - 8'd48;
    cmd_val    = 7'((d0 * 8'd10) + d1);
    cmd_digits = is_digit(chr_val0) && is_digit(chr_val1);
    cmd_ok     = 1'b0;
    // Threshold pairs must stay ordered after the write
    unique case (chr_cmd)
      "A":     cmd_ok = cmd_digits && (cmd_val >= min_temp_q[cmd_zone]);
      "B":     cmd_ok = cmd_digits && (max_temp_q[cmd_zone] >= cmd_val);
      "C":     cmd_ok = cmd_digits && (cmd_val >= min_hum_q[cmd_zone]);
      "D":     cmd_ok = cmd_digits && (max_hum_q[cmd_zone] >= cmd_val);
      "L", "M": cmd_ok = 1'b1;
      default: cmd_ok = 1'b0;
    endcase
    cmd_ok = cmd_ok && cmd_zone_ok;
  end

  always_comb begin
    state_d       = state_q;
    zone_d        = zone_q;
    refresh_cnt_d = refresh_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    t_smp_d       = t_smp_q;
    h_smp_d       = h_smp_q;
    max_temp_d    = max_temp_q;
    min_temp_d    = min_temp_q;
    max_hum_d     = max_hum_q;
    min_hum_d     = min_hum_q;
    manual_d      = manual_q;
    fan_d         = fan_q;
    hum_d         = hum_q;
    alarm_d       = alarm_q;
    fault_d       = fault_q;
    tx_req_d      = tx_req_q && !tx_ack;
    lcd_en_d      = 1'b0;
    cmd_err_d     = 1'b0;
    row1_d        = row1_q;
    row2_d        = row2_q;

    unique case (state_q)
      StIdle: begin
        if (refresh_cnt_q == RefreshLast) begin
          refresh_cnt_d = '0;
          state_d       = StReq;
        end else begin
          refresh_cnt_d = refresh_cnt_q + 32'd1;
        end
      end
      StReq: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (dht_data_ready) begin
          state_d = StEval;
        end else if (wait_cnt_q == TimeoutLast) begin
          fault_d[zone_q] = 1'b1;
          state_d         = StDisp;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      StEval: begin
        t_smp_d         = cur_t;
        h_smp_d         = cur_h;
        fault_d[zone_q] = 1'b0;
        alarm_d[zone_q] = (cur_t < {1'b0, min_temp_q[zone_q]}) ||
                          (cur_h > {1'b0, max_hum_q[zone_q]});
        if (!manual_q[zone_q]) begin
          if (cur_t > max_t8)                fan_d[zone_q] = 1'b1;
          else if (cur_t <= fan_clr_thr)     fan_d[zone_q] = 1'b0;
          if (cur_h < {1'b0, min_hum_q[zone_q]}) hum_d[zone_q] = 1'b1;
          else if ({1'b0, cur_h} >= hum_clr_thr) hum_d[zone_q] = 1'b0;
        end
        state_d = StDisp;
      end
      StDisp: begin
        row1_d   = {"Z", 8'd48 + 8'(zone_q), " T:", t_dd, "C H:", h_dd, "%  "};
        row2_d   = {"F:", fan_q[zone_q] ? StrOn : StrOff, " H:", hum_q[zone_q] ? StrOn : StrOff,
                    " ", alarm_q[zone_q] ? StrAlm : StrOk, " "};
        lcd_en_d = 1'b1;
        tx_req_d = 1'b1;
        zone_d   = (zone_q == ZoneLast) ? '0 : zone_q + 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Commands apply after EVAL so EVAL sees pre-command thresholds; a manual LED write wins
    if (rx_msg_done) begin
      if (cmd_ok) begin
        unique case (chr_cmd)
          "A": max_temp_d[cmd_zone] = cmd_val;
          "B": min_temp_d[cmd_zone] = cmd_val;
          "C": max_hum_d[cmd_zone]  = cmd_val;
          "D": min_hum_d[cmd_zone]  = cmd_val;
          "L": begin
            manual_d[cmd_zone] = 1'b1;
            fan_d[cmd_zone]    = (chr_val0 != "0");
            hum_d[cmd_zone]    = (chr_val1 != "0");
          end
          "M":     manual_d[cmd_zone] = 1'b0;
          default: ;
        endcase
      end else begin
        cmd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      zone_q        <= '0;
      refresh_cnt_q <= '0;
      wait_cnt_q    <= '0;
      t_smp_q       <= '0;
      h_smp_q       <= '0;
      for (int z = 0; z < NUM_ZONES; z++) begin
        max_temp_q[z] <= 7'd18;
        min_temp_q[z] <= 7'd0;
        max_hum_q[z]  <= 7'd35;
        min_hum_q[z]  <= 7'd10;
      end
      manual_q      <= '0;
      fan_q         <= '0;
      hum_q         <= '0;
      alarm_q       <= '0;
      fault_q       <= '0;
      tx_req_q      <= 1'b0;
      lcd_en_q      <= 1'b0;
      cmd_err_q     <= 1'b0;
      row1_q        <= Row1Reset;
      row2_q        <= Row2Reset;
    end else begin
      state_q       <= state_d;
      zone_q        <= zone_d;
      refresh_cnt_q <= refresh_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      t_smp_q       <= t_smp_d;
      h_smp_q       <= h_smp_d;
      max_temp_q    <= max_temp_d;
      min_temp_q    <= min_temp_d;
      max_hum_q     <= max_hum_d;
      min_hum_q     <= min_hum_d;
      manual_q      <= manual_d;
      fan_q         <= fan_d;
      hum_q         <= hum_d;
      alarm_q       <= alarm_d;
      fault_q       <= fault_d;
      tx_req_q      <= tx_req_d;
      lcd_en_q      <= lcd_en_d;
      cmd_err_q     <= cmd_err_d;
      row1_q        <= row1_d;
      row2_q        <= row2_d;
    end
  end

  assign led_fan      = fan_q;
  assign led_hum      = hum_q;
  assign alarm        = alarm_q;
  assign sensor_fault = fault_q;
  assign tx_req       = tx_req_q;
  assign lcd_en       = lcd_en_q;
  assign cmd_err      = cmd_err_q;
  assign lcd_row1     = row1_q;
  assign lcd_row2     = row2_q;

endmodule

// File: tb/tb_multi_zone_climate_ctrl.sv
// Directed bench for multi_zone_climate_ctrl: table of scan periods plus hand-written
// command, handshake and reset sequences.
module tb_multi_zone_climate_ctrl;

  localparam int NZ = 2;
  localparam int RT = 20;
  localparam int TT = 30;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [8*NZ-1:0] temperature, humidity;
  logic [NZ-1:0]   dht_en;
  logic            dht_data_ready;
  logic [7:0]      chr_zone, chr_cmd, chr_val0, chr_val1;
  logic            rx_msg_done, cmd_err, tx_req, tx_ack, lcd_en;
  logic [127:0]    lcd_row1, lcd_row2;
  logic [NZ-1:0]   led_fan, led_hum, alarm, sensor_fault;

  always #5 clk = ~clk;

  multi_zone_climate_ctrl #(
    .NUM_ZONES    (NZ),
    .REFRESH_TICKS(RT),
    .TIMEOUT_TICKS(TT),
    .HYST         (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .temperature   (temperature),
    .humidity      (humidity),
    .dht_en        (dht_en),
    .dht_data_ready(dht_data_ready),
    .chr_zone      (chr_zone),
    .chr_cmd       (chr_cmd),
    .chr_val0      (chr_val0),
    .chr_val1      (chr_val1),
    .rx_msg_done   (rx_msg_done),
    .cmd_err       (cmd_err),
    .tx_req        (tx_req),
    .tx_ack        (tx_ack),
    .lcd_en        (lcd_en),
    .lcd_row1      (lcd_row1),
    .lcd_row2      (lcd_row2),
    .led_fan       (led_fan),
    .led_hum       (led_hum),
    .alarm         (alarm),
    .sensor_fault  (sensor_fault)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int           zone;
    logic [7:0]   t;
    logic [7:0]   h;
    bit           rdy;
    bit           fan;
    bit           hum;
    bit           alm;
    bit           flt;
    logic [127:0] r1;
    logic [127:0] r2;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic wait_dht();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dht_en != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL dht_en wait: got no request, required a request within 200 cycles");
    end
  endtask

  task automatic send_cmd(input string name, input logic [7:0] z, input logic [7:0] c,
                          input logic [7:0] v0, input logic [7:0] v1, input bit exp_err);
    @(negedge clk);
    chr_zone    = z;
    chr_cmd     = c;
    chr_val0    = v0;
    chr_val1    = v1;
    rx_msg_done = 1'b1;
    @(negedge clk);
    rx_msg_done = 1'b0;
    chk(name, 32'(cmd_err), 32'(exp_err));
    @(negedge clk);
    chk({name, " err clears"}, 32'(cmd_err), 32'd0);
  endtask

  task automatic run_entry(input int i);
    vec_t v;
    bit   seen;
    v = tbl[i];
    temperature[8*v.zone +: 8] = v.t;
    humidity[8*v.zone +: 8]    = v.h;
    wait_dht();
    chk($sformatf("e%0d dht_en zone", i), 32'(dht_en), 32'd1 << v.zone);
    if (v.rdy) begin
      repeat (10) @(negedge clk);
      chk($sformatf("e%0d dht_en held", i), 32'(dht_en), 32'd1 << v.zone);
      dht_data_ready = 1'b1;
      @(negedge clk);
      dht_data_ready = 1'b0;
      chk($sformatf("e%0d dht_en drop", i), 32'(dht_en), 32'd0);
    end
    seen = 1'b0;
    for (int j = 0; j < TT + 60; j++) begin
      if (lcd_en) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("e%0d lcd_en seen", i), 32'(seen), 32'd1);
    chk($sformatf("e%0d led_fan", i), 32'(led_fan[v.zone]), 32'(v.fan));
    chk($sformatf("e%0d led_hum", i), 32'(led_hum[v.zone]), 32'(v.hum));
    chk($sformatf("e%0d alarm", i), 32'(alarm[v.zone]), 32'(v.alm));
    chk($sformatf("e%0d sensor_fault", i), 32'(sensor_fault[v.zone]), 32'(v.flt));
    chk_row($sformatf("e%0d row1", i), lcd_row1, v.r1);
    chk_row($sformatf("e%0d row2", i), lcd_row2, v.r2);
    chk($sformatf("e%0d tx_req", i), 32'(tx_req), 32'd1);
    @(negedge clk);
    chk($sformatf("e%0d lcd_en pulse", i), 32'(lcd_en), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{0, 8'd25,  8'd40, 1, 1, 0, 0, 0, "Z0 T:25C H:40%  ", "F:ON  H:OFF OK  "};
    tbl[1]  = '{1, 8'd10,  8'd20, 1, 0, 0, 0, 0, "Z1 T:10C H:20%  ", "F:OFF H:OFF OK  "};
    tbl[2]  = '{0, 8'd17,  8'd40, 1, 1, 0, 0, 0, "Z0 T:17C H:40%  ", "F:ON  H:OFF OK  "};
    tbl[3]  = '{1, 8'd5,   8'd8,  1, 0, 1, 0, 0, "Z1 T:05C H:08%  ", "F:OFF H:ON  OK  "};
    tbl[4]  = '{0, 8'd0,   8'd0,  0, 1, 0, 0, 1, "Z0 T:--C H:--%  ", "F:ON  H:OFF OK  "};
    tbl[5]  = '{1, 8'd150, 8'd11, 1, 1, 1, 0, 0, "Z1 T:99C H:11%  ", "F:ON  H:ON  OK  "};
    tbl[6]  = '{0, 8'd16,  8'd40, 1, 0, 0, 0, 0, "Z0 T:16C H:40%  ", "F:OFF H:OFF OK  "};
    tbl[7]  = '{1, 8'd10,  8'd60, 1, 0, 0, 1, 0, "Z1 T:10C H:60%  ", "F:OFF H:OFF ALM "};
    tbl[8]  = '{0, 8'd6,   8'd40, 1, 1, 0, 0, 0, "Z0 T:06C H:40%  ", "F:ON  H:OFF OK  "};
    tbl[9]  = '{1, 8'd10,  8'd5,  1, 1, 0, 0, 0, "Z1 T:10C H:05%  ", "F:ON  H:OFF OK  "};
    tbl[10] = '{0, 8'd6,   8'd40, 1, 1, 0, 0, 0, "Z0 T:06C H:40%  ", "F:ON  H:OFF OK  "};
    tbl[11] = '{1, 8'd10,  8'd5,  1, 0, 1, 0, 0, "Z1 T:10C H:05%  ", "F:OFF H:ON  OK  "};
    tbl[12] = '{0, 8'd6,   8'd40, 1, 1, 0, 0, 0, "Z0 T:06C H:40%  ", "F:ON  H:OFF OK  "};

    rst_n          = 1'b0;
    temperature    = '0;
    humidity       = '0;
    dht_data_ready = 1'b0;
    chr_zone       = '0;
    chr_cmd        = '0;
    chr_val0       = '0;
    chr_val1       = '0;
    rx_msg_done    = 1'b0;
    tx_ack         = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset dht_en", 32'(dht_en), 32'd0);
    chk("reset led_fan", 32'(led_fan), 32'd0);
    chk("reset led_hum", 32'(led_hum), 32'd0);
    chk("reset alarm", 32'(alarm), 32'd0);
    chk("reset sensor_fault", 32'(sensor_fault), 32'd0);
    chk("reset tx_req", 32'(tx_req), 32'd0);
    chk("reset lcd_en", 32'(lcd_en), 32'd0);
    chk("reset cmd_err", 32'(cmd_err), 32'd0);
    chk_row("reset row1", lcd_row1, "  Cold Storage  ");
    chk_row("reset row2", lcd_row2, "     Welcome    ");

    // Zone 0 max_hum raised so the 40 %RH scan is not an alarm
    send_cmd("cmd 0C50", "0", "C", "5", "0", 1'b0);

    for (int i = 0; i < 8; i++) run_entry(i);

    chk("tx_req before ack", 32'(tx_req), 32'd1);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    chk("tx_req after ack", 32'(tx_req), 32'd0);

    send_cmd("cmd 0A05", "0", "A", "0", "5", 1'b0);
    send_cmd("cmd 0B09", "0", "B", "0", "9", 1'b1);
    send_cmd("cmd 7A20", "7", "A", "2", "0", 1'b1);
    send_cmd("cmd 0X11", "0", "X", "1", "1", 1'b1);
    send_cmd("cmd 0A1x", "0", "A", "1", "x", 1'b1);
    send_cmd("cmd 0C05", "0", "C", "0", "5", 1'b1);
    send_cmd("cmd 1L10", "1", "L", "1", "0", 1'b0);
    chk("manual led_fan[1]", 32'(led_fan[1]), 32'd1);
    chk("manual led_hum[1]", 32'(led_hum[1]), 32'd0);

    run_entry(8);
    run_entry(9);
    send_cmd("cmd 1M00", "1", "M", "0", "0", 1'b0);
    run_entry(10);
    run_entry(11);
    run_entry(12);

    // Reset while zone 1 is waiting for its sensor
    wait_dht();
    repeat (3) @(negedge clk);
    chk("pre-reset dht_en", 32'(dht_en), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async reset dht_en", 32'(dht_en), 32'd0);
    chk("async reset led_fan", 32'(led_fan), 32'd0);
    chk("async reset tx_req", 32'(tx_req), 32'd0);
    chk_row("async reset row1", lcd_row1, "  Cold Storage  ");
    @(negedge clk);
    rst_n = 1'b1;
    wait_dht();
    chk("post-reset zone", 32'(dht_en), 32'd1);
    chk_row("post-reset row1", lcd_row1, "  Cold Storage  ");
    chk_row("post-reset row2", lcd_row2, "     Welcome    ");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_zone_climate_ctrl.md
MULTI_ZONE_CLIMATE_CTRL -- requirements
Module: multi_zone_climate_ctrl

Interface
REQ-001 SHALL have parameter NUM_ZONES, default 2: zone count, legal range 1..4.
REQ-002 SHALL have parameter REFRESH_TICKS, default 500_000: clk cycles between zone scans.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 100_000: maximum wait for sensor data.
REQ-004 SHALL have parameter HYST, default 2: hysteresis band in degrees C / %RH.
REQ-005 SHALL have clk  in  1  system clock (1 MHz); one clock domain only.
REQ-006 SHALL have rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have temperature  in  8*NUM_ZONES  packed per-zone temperature; zone z occupies [8z+7:8z].
REQ-008 SHALL have humidity  in  8*NUM_ZONES  packed per-zone humidity.
REQ-009 SHALL have dht_en  out  NUM_ZONES  one-hot sensor read request.
REQ-010 SHALL have dht_data_ready  in  1  sensor data valid for the requested zone.
REQ-011 SHALL have chr_zone, chr_cmd, chr_val0, chr_val1  in  8 each  ASCII command fields.
REQ-012 SHALL have rx_msg_done  in  1  one-cycle pulse; all command fields are valid in that cycle.
REQ-013 SHALL have cmd_err  out  1  one-cycle pulse on a rejected command.
REQ-014 SHALL have tx_req  out  1 and tx_ack  in  1  metrics-send handshake.
REQ-015 SHALL have lcd_en  out  1, lcd_row1 and lcd_row2  out  128 each  16 ASCII characters per row.
REQ-016 SHALL have led_fan, led_hum, alarm, sensor_fault  out  NUM_ZONES each  per-zone status.

Function
REQ-017 SHALL scan zones round-robin 0..NUM_ZONES-1 and wrap to 0, one zone per refresh period.
REQ-018 SHALL use FSM states IDLE -> REQ -> WAIT -> EVAL -> DISP -> IDLE.
- IDLE: leaves when refresh counter reaches REFRESH_TICKS-1; counter then clears.
- REQ: one cycle; asserts dht_en[z].
REQ-019 SHALL hold dht_en[z] high through WAIT and drop it on the cycle after dht_data_ready is seen high.
REQ-020 SHALL handle WAIT timeout as follows: if TIMEOUT_TICKS cycles elapse without dht_data_ready, set sensor_fault[z], hold led_fan[z] and led_hum[z], and go to DISP, skipping EVAL.
REQ-021 SHALL, in EVAL, sample temperature/humidity of zone z and clear sensor_fault[z].
REQ-022 SHALL, in auto mode, drive led_fan[z] with hysteresis.
- Set when T > max_temp.
- Clear when T <= max_temp - HYST, saturated at 0.
- Otherwise hold.
REQ-023 SHALL, in auto mode, drive led_hum[z] with hysteresis.
- Set when H < min_hum.
- Clear when H >= min_hum + HYST.
- Otherwise hold.
REQ-024 SHALL set alarm[z] when T < min_temp or H > max_hum, and clear it otherwise; alarm is evaluated in EVAL only.
REQ-025 SHALL, in DISP, write both LCD rows, pulse lcd_en for one cycle, and set tx_req.
- lcd_row1 = "Z" z-digit " T:" dd "C H:" dd "%  ".
- lcd_row1 shows "--" instead of dd when sensor_fault[z] is set.
- lcd_row2 = "F:" ON /OFF " H:" ON /OFF " " ALM/OK  " ".
REQ-026 SHALL render dd as two decimal digits, zero-padded, with values > 99 shown as "99".
REQ-027 SHALL hold tx_req until tx_ack is seen high, then clear it on the next cycle; a new DISP while tx_req is high keeps it high.
REQ-028 SHALL accept commands in any FSM state, applied on the cycle after rx_msg_done.
- chr_zone '0'..NUM_ZONES-1 selects the target zone.
- 'A'/'B'/'C'/'D' write max_temp/min_temp/max_hum/min_hum = (val0-'0')*10 + (val1-'0'), stored 7 bits.
- 'L' sets manual mode: led_fan = (val0 != '0'), led_hum = (val1 != '0').
- 'M' returns the zone to auto mode.
REQ-029 SHALL reject a command, with no state change and a cmd_err pulse, if any of the following holds.
- Zone is out of range.
- Command character is unknown.
- For A-D, either value is not a digit '0'..'9'.
- The write would make max_temp < min_temp or max_hum < min_hum.
REQ-030 SHALL give EVAL the pre-command thresholds when a command and EVAL for the same zone coincide.

Reset
REQ-031 SHALL, while rst_n is low, force the state below asynchronously.
- FSM in IDLE, all counters 0, zone index 0.
- dht_en, led_fan, led_hum, alarm, sensor_fault, tx_req, lcd_en and cmd_err all 0.
REQ-032 SHALL, on reset, set every zone to auto mode with max_temp=18, min_temp=0, max_hum=35, min_hum=10.
REQ-033 SHALL, on reset, set lcd_row1 = "  Cold Storage  " and lcd_row2 = "     Welcome    ".
REQ-034 SHALL, on reset asserted mid-WAIT, drop dht_en immediately and restart the scan at zone 0.

Verification
REQ-035 SHALL verify scan: NUM_ZONES=2, zone0 T=25 H=40, ready after 10 cycles -> led_fan[0]=1, led_hum[0]=0, row1 "Z0 T:25C H:40%  ", row2 "F:ON  H:OFF OK  ".
REQ-036 SHALL verify hysteresis: zone0 fan on; T=17 -> fan stays 1; T=16 -> fan 0.
REQ-037 SHALL verify timeout: no ready for TIMEOUT_TICKS -> sensor_fault[0]=1, row1 "Z0 T:--C H:--%  ", LEDs held.
REQ-038 SHALL verify commands.
- "0A05" with min_temp=0 -> max_temp=5, no cmd_err.
- "0B09" -> rejected, cmd_err pulse.
- "7A20" -> rejected, cmd_err pulse.
REQ-039 SHALL verify manual mode: "1L10" -> led_fan[1]=1, led_hum[1]=0, unchanged by EVAL; after "1M", the next EVAL restores auto.
REQ-040 SHALL verify reset: rst_n low during WAIT -> dht_en=0 the same cycle; after release, the first request goes to zone 0 with reset LCD text.
